track_mem_arbiter: RTL and testbench
====================================

Name: track_mem_arbiter

Overview:
- Shares one single-port track-map BRAM between the three display viewers: track view (req 0), racer view (req 1) and forward view (req 2).
- Each viewer issues pixel-address reads over a valid/ready handshake. The arbiter grants at most one read per cycle, round-robin, with an optional fixed-priority override for req 0.
- It returns the BRAM data to the winning requester at a fixed latency.
- It sits between the viewers and the track ROM in the clk_65mhz pixel domain.

Parameters:
- ADDR_W, 17, track-map address width.
- DATA_W, 4, track-map entry width.
- BRAM_LAT, 2, BRAM read latency in cycles (address presented to data valid), range 1..4.

Ports:
- clk_in  input  1  pixel clock (65 MHz)
- rst_in  input  1  asynchronous, active-high reset
- req_valid_in  input  3  per-requester read request
- req_addr_in  input  3xADDR_W  per-requester read address, packed [2:0][ADDR_W-1:0]
- req_ready_out  output  3  one-hot grant; handshake when valid & ready
- prio0_in  input  1  when high, req 0 wins whenever it is valid
- mem_addr_out  output  ADDR_W  BRAM address, registered
- mem_en_out  output  1  BRAM read enable, registered
- mem_data_in  input  DATA_W  BRAM read data
- rsp_valid_out  output  3  one-hot response strobe
- rsp_data_out  output  DATA_W  response data, registered, shared by all requesters

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous and active-high.
- Reset state: all outputs 0; RR pointer = 0 (req 0 highest); tag pipeline cleared.
- Grant logic (combinational from req_valid_in, pointer and prio0_in):
  - At most one bit of req_ready_out is set, and only for a requester whose valid is high.
  - No valid requests → req_ready_out = 0.
  - req_ready_out never depends on whether a requester's data is still pending.
- RR order: starting at the pointer, scan 0→1→2 with wrap; the first valid requester wins.
- Pointer update: after a handshake by requester i, pointer <= (i+1) mod 3. With no handshake, the pointer holds.
- prio0_in override: prio0_in=1 and req_valid_in[0]=1 → req 0 granted and the pointer is NOT updated. Otherwise normal RR applies.
- Accept pipeline (handshake sampled at edge of cycle 0):
  - Cycle 1: mem_addr_out = accepted address, mem_en_out = 1. With no accept, mem_en_out = 0 and mem_addr_out holds its last value.
  - Cycle 1+BRAM_LAT: mem_data_in valid. It is registered into rsp_data_out.
  - Cycle 2+BRAM_LAT: rsp_valid_out[i] = 1 for exactly one cycle, with rsp_data_out = the data.
  - Total latency is BRAM_LAT+2 cycles (4 at default). It is fixed and independent of contention.
- Tag pipeline: depth BRAM_LAT+1, carrying a one-hot requester tag. It is fully pipelined, so back-to-back accepts every cycle yield back-to-back responses in accept order.
- rsp_data_out: holds its last value when no response is valid; it is not cleared.
- Reset mid-operation: in-flight reads are discarded. No rsp_valid_out pulse occurs for any request accepted before reset.
- Requester contract: a requester holds its address stable while valid & !ready. The arbiter does not buffer unaccepted requests.
- Starvation bound: with prio0_in=0, a continuously valid requester is granted within 3 cycles.

Optional Feature:
- Macro: TRACK_MEM_ARB_STATS_EN.
- When defined:
  - Adds output port stall_cnt_out, 3x16, packed [2:0][15:0].
  - Counter i increments each cycle req_valid_in[i] & !req_ready_out[i], saturating at 16'hFFFF.
  - Adds input stats_clr_in (1 bit), a synchronous clear of all counters; clear wins over increment in the same cycle.
  - rst_in clears the counters.
- When undefined: neither port exists; no counter logic.

Test Plan:
- Single requester: req 1 valid, addr 0x00ABC, mem model returns 4'h7 at BRAM_LAT=2.
  → ready[1] in cycle 0; mem_en_out=1 and mem_addr_out=0x00ABC in cycle 1; rsp_valid_out=3'b010 with data 4'h7 in cycle 4.
- All three valid continuously for 9 cycles from reset.
  → grants 0,1,2,0,1,2,0,1,2; responses in the same order, one per cycle starting at cycle 4.
- prio0_in=1, all valid for 4 cycles, then prio0_in=0.
  → grants 0,0,0,0, then 0,1,2 (pointer unchanged by the priority grants).
- Reqs 0 and 2 valid, pointer=1.
  → req 2 granted first, then 0, then 2.
- Accept 3 reads, assert rst_in in cycle 2 for 1 cycle.
  → all outputs 0 during reset; no rsp_valid_out ever pulses for the three reads; next request from req 2 is granted with pointer=0 semantics.
- (STATS_EN) Req 2 valid with reqs 0 and 1 hogging for 10 cycles.
  → stall_cnt_out[2] matches its number of cycles valid & !ready; stats_clr_in → 0; forced count at 16'hFFFF stays 16'hFFFF.

Source files
------------

// File: rtl/track_mem_arbiter.sv
// Round-robin arbiter that shares the track-map BRAM between the track, racer and forward viewers.
// Optional stall counters are enabled with `define TRACK_MEM_ARB_STATS_EN.
module track_mem_arbiter #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned BRAM_LAT = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [2:0]             req_valid_in,
  input  logic [2:0][ADDR_W-1:0] req_addr_in,
  output logic [2:0]             req_ready_out,
  input  logic                   prio0_in,
  output logic [ADDR_W-1:0]      mem_addr_out,
  output logic                   mem_en_out,
  input  logic [DATA_W-1:0]      mem_data_in,
  output logic [2:0]             rsp_valid_out,
  output logic [DATA_W-1:0]      rsp_data_out
`ifdef TRACK_MEM_ARB_STATS_EN
  ,
  input  logic                   stats_clr_in,
  output logic [2:0][15:0]       stall_cnt_out
`endif
);

  localparam int unsigned TAG_D = BRAM_LAT + 1;

  logic [1:0]             ptr;
  logic [1:0]             ptr_nxt;
  logic [2:0]             grant;
  logic                   prio_hit;
  logic [ADDR_W-1:0]      accept_addr;
  logic [TAG_D-1:0][2:0]  tag_pipe;

  // Grant: priority override for req 0, otherwise scan from the pointer with wrap
  always_comb begin
    grant    = 3'b000;
    prio_hit = 1'b0;
    if (!rst_in) begin
      if (prio0_in && req_valid_in[0]) begin
        grant    = 3'b001;
        prio_hit = 1'b1;
      end else begin
        case (ptr)
          2'd1: begin
            if      (req_valid_in[1]) grant = 3'b010;
            else if (req_valid_in[2]) grant = 3'b100;
            else if (req_valid_in[0]) grant = 3'b001;
          end
          2'd2: begin
            if      (req_valid_in[2]) grant = 3'b100;
            else if (req_valid_in[0]) grant = 3'b001;
            else if (req_valid_in[1]) grant = 3'b010;
          end
          default: begin
            if      (req_valid_in[0]) grant = 3'b001;
            else if (req_valid_in[1]) grant = 3'b010;
            else if (req_valid_in[2]) grant = 3'b100;
          end
        endcase
      end
    end
  end

  assign req_ready_out = grant;

  // Priority grants leave the round-robin position untouched
  always_comb begin
    ptr_nxt = ptr;
    if (!prio_hit) begin
      if      (grant[0]) ptr_nxt = 2'd1;
      else if (grant[1]) ptr_nxt = 2'd2;
      else if (grant[2]) ptr_nxt = 2'd0;
    end
  end

  always_comb begin
    accept_addr = req_addr_in[0];
    if      (grant[1]) accept_addr = req_addr_in[1];
    else if (grant[2]) accept_addr = req_addr_in[2];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ptr          <= 2'd0;
      mem_addr_out <= '0;
      mem_en_out   <= 1'b0;
    end else begin
      ptr        <= ptr_nxt;
      mem_en_out <= |grant;
      if (|grant) mem_addr_out <= accept_addr;
    end
  end

  // Tag pipeline tracks the owner of each in-flight read; last stage aligns with BRAM data
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      tag_pipe      <= '0;
      rsp_valid_out <= 3'b000;
      rsp_data_out  <= '0;
    end else begin
      tag_pipe      <= {tag_pipe[TAG_D-2:0], grant};
      rsp_valid_out <= tag_pipe[TAG_D-1];
      if (|tag_pipe[TAG_D-1]) rsp_data_out <= mem_data_in;
    end
  end

`ifdef TRACK_MEM_ARB_STATS_EN
  logic [2:0] stall;
  assign stall = req_valid_in & ~req_ready_out;

  // Saturating per-requester stall counters; clear beats increment
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stall_cnt_out <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stats_clr_in) begin
          stall_cnt_out[i] <= 16'h0000;
        end else if (stall[i] && (stall_cnt_out[i] != 16'hFFFF)) begin
          stall_cnt_out[i] <= stall_cnt_out[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_track_mem_arbiter.sv
// Randomized bench for track_mem_arbiter against a cycle-history reference model.
// Define TRACK_MEM_ARB_STATS_EN to also check the stall counters.
module tb_track_mem_arbiter;

  localparam int unsigned ADDR_W   = 17;
  localparam int unsigned DATA_W   = 4;
  localparam int unsigned BRAM_LAT = 2;
  localparam int          MAXC     = 8192;

  logic                   clk_in;
  logic                   rst_in;
  logic [2:0]             req_valid_in;
  logic [2:0][ADDR_W-1:0] req_addr_in;
  logic [2:0]             req_ready_out;
  logic                   prio0_in;
  logic [ADDR_W-1:0]      mem_addr_out;
  logic                   mem_en_out;
  logic [DATA_W-1:0]      mem_data_in;
  logic [2:0]             rsp_valid_out;
  logic [DATA_W-1:0]      rsp_data_out;
`ifdef TRACK_MEM_ARB_STATS_EN
  logic                   stats_clr_in;
  logic [2:0][15:0]       stall_cnt_out;
`endif

  track_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BRAM_LAT(BRAM_LAT)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .req_valid_in  (req_valid_in),
    .req_addr_in   (req_addr_in),
    .req_ready_out (req_ready_out),
    .prio0_in      (prio0_in),
    .mem_addr_out  (mem_addr_out),
    .mem_en_out    (mem_en_out),
    .mem_data_in   (mem_data_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out)
`ifdef TRACK_MEM_ARB_STATS_EN
    ,
    .stats_clr_in  (stats_clr_in),
    .stall_cnt_out (stall_cnt_out)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [DATA_W-1:0] bram_f(input logic [ADDR_W-1:0] a);
    return DATA_W'(a ^ (a >> 4) ^ (a >> 9) ^ (a >> 13));
  endfunction

  // BRAM model: data for the address presented in cycle c appears in cycle c+BRAM_LAT
  logic [ADDR_W-1:0] addr_d [BRAM_LAT];
  always @(posedge clk_in) begin
    addr_d[0] <= mem_addr_out;
    for (int k = 1; k < BRAM_LAT; k++) addr_d[k] <= addr_d[k-1];
  end
  assign mem_data_in = bram_f(addr_d[BRAM_LAT-1]);

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rst_cyc = -1;
  int ptr_m = 0;
  logic [ADDR_W-1:0] last_addr_m = '0;
  logic [DATA_W-1:0] last_data_m = '0;
  bit                hv [MAXC];
  int                hid[MAXC];
  logic [ADDR_W-1:0] ha [MAXC];
  logic [2:0]        pend = 3'b000;
  logic [2:0][15:0]  cnt_m = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic check_pipe();
    int c1;
    int c2;
    logic              en_e;
    logic [2:0]        rv_e;
    c1   = cyc - 1;
    c2   = cyc - int'(BRAM_LAT) - 2;
    en_e = 1'b0;
    rv_e = 3'b000;
    if (c1 >= 0 && c1 > rst_cyc && hv[c1]) begin
      en_e        = 1'b1;
      last_addr_m = ha[c1];
    end
    if (c2 >= 0 && c2 > rst_cyc && hv[c2]) begin
      rv_e            = 3'b000;
      rv_e[hid[c2]]   = 1'b1;
      last_data_m     = bram_f(ha[c2]);
    end
    check("mem_en", 64'(mem_en_out), 64'(en_e));
    check("mem_addr", 64'(mem_addr_out), 64'(last_addr_m));
    check("rsp_valid", 64'(rsp_valid_out), 64'(rv_e));
    check("rsp_data", 64'(rsp_data_out), 64'(last_data_m));
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance model
  task automatic step(input logic [2:0] v, input logic p, input logic clr);
    logic [2:0] vv;
    logic [2:0] eg;
    int w;
    bit ovr;
    for (int i = 0; i < 3; i++) begin
      if (pend[i]) begin
        vv[i] = 1'b1;
      end else begin
        vv[i] = v[i];
        if (v[i]) req_addr_in[i] = ADDR_W'($urandom);
      end
    end
    req_valid_in = vv;
    prio0_in     = p;
`ifdef TRACK_MEM_ARB_STATS_EN
    stats_clr_in = clr;
`endif
    @(negedge clk_in);
    w   = -1;
    ovr = 1'b0;
    if (p && vv[0]) begin
      w   = 0;
      ovr = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) begin
        int idx;
        idx = (ptr_m + k) % 3;
        if (w < 0 && vv[idx]) w = idx;
      end
    end
    eg = 3'b000;
    if (w >= 0) eg[w] = 1'b1;
    check("ready", 64'(req_ready_out), 64'(eg));
    check_pipe();
`ifdef TRACK_MEM_ARB_STATS_EN
    check("stall_cnt", 64'(stall_cnt_out), 64'(cnt_m));
    for (int i = 0; i < 3; i++) begin
      if (clr) cnt_m[i] = 16'h0000;
      else if (vv[i] && !eg[i] && cnt_m[i] != 16'hFFFF) cnt_m[i] = cnt_m[i] + 16'd1;
    end
`else
    if (clr) cnt_m = '0;
`endif
    hv[cyc] = (w >= 0);
    hid[cyc] = (w >= 0) ? w : 0;
    ha[cyc]  = (w >= 0) ? req_addr_in[w] : '0;
    if (w >= 0 && !ovr) ptr_m = (w + 1) % 3;
    pend = vv & ~eg;
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  // Async reset for one cycle with requests pending; everything must read zero
  task automatic do_reset();
    rst_in       = 1'b1;
    req_valid_in = 3'b111;
    prio0_in     = 1'b0;
    #1;
    check("rst_ready", 64'(req_ready_out), 64'd0);
    check("rst_en", 64'(mem_en_out), 64'd0);
    check("rst_addr", 64'(mem_addr_out), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid_out), 64'd0);
    check("rst_rsp_data", 64'(rsp_data_out), 64'd0);
`ifdef TRACK_MEM_ARB_STATS_EN
    check("rst_stall", 64'(stall_cnt_out), 64'd0);
`endif
    ptr_m       = 0;
    last_addr_m = '0;
    last_data_m = '0;
    pend        = 3'b000;
    cnt_m       = '0;
    hv[cyc]     = 1'b0;
    rst_cyc     = cyc;
    @(posedge clk_in);
    #1;
    rst_in       = 1'b0;
    req_valid_in = 3'b000;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, 1'b0, 1'b0);
  endtask

  initial begin
    rst_in       = 1'b1;
    req_valid_in = 3'b000;
    req_addr_in  = '0;
    prio0_in     = 1'b0;
`ifdef TRACK_MEM_ARB_STATS_EN
    stats_clr_in = 1'b0;
`endif
    @(posedge clk_in);
    #1;
    do_reset();

    // single requester
    step(3'b010, 1'b0, 1'b0);
    idle(6);

    // all three continuously valid from reset
    do_reset();
    for (int i = 0; i < 9; i++) step(3'b111, 1'b0, 1'b0);
    idle(6);

    // priority override leaves the pointer alone
    do_reset();
    for (int i = 0; i < 4; i++) step(3'b111, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b111, 1'b0, 1'b0);
    idle(6);

    // reqs 0 and 2 with pointer at 1
    do_reset();
    step(3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(3'b101, 1'b0, 1'b0);
    idle(6);

    // reset with reads in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(3'b111, 1'b0, 1'b0);
    do_reset();
    step(3'b100, 1'b0, 1'b0);
    idle(6);

    // hogging under priority, then clear
    do_reset();
    for (int i = 0; i < 10; i++) step(3'b111, 1'b1, 1'b0);
    step(3'b111, 1'b1, 1'b1);
    step(3'b000, 1'b0, 1'b0);
    idle(6);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(3'($urandom_range(0, 7)),
             ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 31) == 0));
      end
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
